// File: rtl/bram_test_sequencer_pkg.sv
// Shared types and constants for the BRAM self-test sequencer.
// Result word layout: {timeout, aborted, 6'b0, fail_cnt[7:0], iter_cnt[15:0]}.
package bram_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_MAX,
    ST_SET_SEED,
    ST_WAIT,
    ST_CHECK,
    ST_REPORT,
    ST_DONE
  } seq_state_t;

  localparam int RESULT_TIMEOUT_BIT  = 31;
  localparam int RESULT_ABORT_BIT    = 30;
  localparam int STATUS_MISMATCH_BIT = 0;

  localparam logic [31:0] DEFAULT_SEED_STEP      = 32'h9E37_79B9;
  localparam logic [31:0] DEFAULT_TIMEOUT_CYCLES = 32'd50_000_000;

  function automatic logic [31:0] pack_result(
    input logic        timeout,
    input logic        aborted,
    input logic [7:0]  fail_cnt,
    input logic [15:0] iter_cnt
  );
    logic [31:0] r;
    r                     = {8'b0, fail_cnt, iter_cnt};
    r[RESULT_TIMEOUT_BIT] = timeout;
    r[RESULT_ABORT_BIT]   = aborted;
    return r;
  endfunction

endpackage

// File: rtl/bram_test_sequencer.sv
// Autonomous run sequencer for the BRAM self-test engine: one addr_max write, then
// N seed / status / check iterations, ending in a clear-on-read summary word.
//
// state    | meaning
// IDLE     | waiting for start; config sampled on start
// SET_MAX  | offering addr_max to bram_test
// SET_SEED | offering current seed to bram_test
// WAIT     | accepting status, timeout timer running
// CHECK    | update counters, advance seed, decide next iteration
// REPORT   | summary first presented, busy released
// DONE     | summary held until read
module bram_test_sequencer
  import bram_test_sequencer_pkg::*;
#(
  parameter logic [31:0] SEED_STEP      = DEFAULT_SEED_STEP,
  parameter logic [31:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_iterations,
  input  logic [31:0] cfg_addr_max,
  input  logic [31:0] cfg_seed,
  output logic        busy,
  output logic [31:0] addr_max_tdata,
  output logic        addr_max_tvalid,
  input  logic        addr_max_tready,
  output logic [31:0] seed_tdata,
  output logic        seed_tvalid,
  input  logic        seed_tready,
  input  logic [31:0] status_tdata,
  input  logic        status_tvalid,
  output logic        status_tready,
  output logic [31:0] result_tdata,
  output logic        result_tvalid,
  input  logic        result_tready
);

  seq_state_t  state;
  logic [15:0] iterations;
  logic [15:0] iter_cnt;
  logic [7:0]  fail_cnt;
  logic [31:0] addr_max_q;
  logic [31:0] cur_seed;
  logic [31:0] timer;
  logic        mismatch_q;
  logic        timeout_flag;
  logic        aborted_flag;

  logic addr_max_xfer;
  logic seed_xfer;
  logic status_xfer;
  logic status_unused;

  assign addr_max_xfer = addr_max_tvalid && addr_max_tready;
  assign seed_xfer     = seed_tvalid && seed_tready;
  assign status_xfer   = status_tvalid && status_tready;
  assign status_unused = ^status_tdata[31:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      iterations   <= 16'd1;
      iter_cnt     <= '0;
      fail_cnt     <= '0;
      addr_max_q   <= '0;
      cur_seed     <= '0;
      timer        <= '0;
      mismatch_q   <= 1'b0;
      timeout_flag <= 1'b0;
      aborted_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            iterations   <= (cfg_iterations == 16'd0) ? 16'd1 : cfg_iterations;
            addr_max_q   <= cfg_addr_max;
            cur_seed     <= cfg_seed;
            iter_cnt     <= '0;
            fail_cnt     <= '0;
            timer        <= '0;
            timeout_flag <= 1'b0;
            aborted_flag <= 1'b0;
            state        <= ST_SET_MAX;
          end
        end
        ST_SET_MAX: begin
          if (abort) begin
            aborted_flag <= 1'b1;
            state        <= ST_REPORT;
          end else if (addr_max_xfer) begin
            state <= ST_SET_SEED;
          end
        end
        ST_SET_SEED: begin
          if (abort) begin
            aborted_flag <= 1'b1;
            state        <= ST_REPORT;
          end else if (seed_xfer) begin
            timer <= TIMEOUT_CYCLES - 32'd1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A status accepted on the abort cycle still gets counted before reporting.
          if (status_xfer) begin
            mismatch_q <= status_tdata[STATUS_MISMATCH_BIT];
            if (abort) aborted_flag <= 1'b1;
            state <= ST_CHECK;
          end else if (abort) begin
            aborted_flag <= 1'b1;
            state        <= ST_REPORT;
          end else if (timer == 32'd0) begin
            timeout_flag <= 1'b1;
            state        <= ST_REPORT;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch_q && (fail_cnt != 8'hFF)) fail_cnt <= fail_cnt + 8'd1;
          iter_cnt <= iter_cnt + 16'd1;
          cur_seed <= cur_seed + SEED_STEP;
          if (abort) aborted_flag <= 1'b1;
          if (abort || aborted_flag || ((iter_cnt + 16'd1) == iterations))
            state <= ST_REPORT;
          else
            state <= ST_SET_SEED;
        end
        ST_REPORT: begin
          state <= result_tready ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (result_tready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decoded from registered state only; no input reaches an output.
  always_comb begin
    busy            = 1'b0;
    addr_max_tvalid = 1'b0;
    seed_tvalid     = 1'b0;
    status_tready   = 1'b0;
    result_tvalid   = 1'b0;
    result_tdata    = '0;
    addr_max_tdata  = addr_max_q;
    seed_tdata      = cur_seed;
    case (state)
      ST_SET_MAX: begin
        busy            = 1'b1;
        addr_max_tvalid = 1'b1;
      end
      ST_SET_SEED: begin
        busy        = 1'b1;
        seed_tvalid = 1'b1;
      end
      ST_WAIT: begin
        busy          = 1'b1;
        status_tready = 1'b1;
      end
      ST_CHECK: busy = 1'b1;
      ST_REPORT, ST_DONE: begin
        result_tvalid = 1'b1;
        result_tdata  = pack_result(timeout_flag, aborted_flag, fail_cnt, iter_cnt);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bram_test_sequencer.sv
// Directed-plus-random bench for bram_test_sequencer; expected seeds and summary
// words come from run-level arithmetic on the chosen configuration and statuses.
module tb_bram_test_sequencer;

  localparam logic [31:0] SEED_STEP = 32'h9E37_79B9;
  localparam int          TIMEOUT   = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] cfg_iterations;
  logic [31:0] cfg_addr_max;
  logic [31:0] cfg_seed;
  logic        busy;
  logic [31:0] addr_max_tdata;
  logic        addr_max_tvalid;
  logic        addr_max_tready;
  logic [31:0] seed_tdata;
  logic        seed_tvalid;
  logic        seed_tready;
  logic [31:0] status_tdata;
  logic        status_tvalid;
  logic        status_tready;
  logic [31:0] result_tdata;
  logic        result_tvalid;
  logic        result_tready;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_result;

  bram_test_sequencer #(
    .TIMEOUT_CYCLES(32'(TIMEOUT))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_iterations (cfg_iterations),
    .cfg_addr_max   (cfg_addr_max),
    .cfg_seed       (cfg_seed),
    .busy           (busy),
    .addr_max_tdata (addr_max_tdata),
    .addr_max_tvalid(addr_max_tvalid),
    .addr_max_tready(addr_max_tready),
    .seed_tdata     (seed_tdata),
    .seed_tvalid    (seed_tvalid),
    .seed_tready    (seed_tready),
    .status_tdata   (status_tdata),
    .status_tvalid  (status_tvalid),
    .status_tready  (status_tready),
    .result_tdata   (result_tdata),
    .result_tvalid  (result_tvalid),
    .result_tready  (result_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_addr_max_tvalid"}, addr_max_tvalid, 1'b0);
    chk({tag, "_seed_tvalid"}, seed_tvalid, 1'b0);
    chk({tag, "_status_tready"}, status_tready, 1'b0);
    chk({tag, "_result_tvalid"}, result_tvalid, 1'b0);
    chk({tag, "_result_tdata"}, result_tdata, 32'h0);
  endtask

  // stall: 0 = always ready, 1 = random ready, 2 = seed_tready held low 10 cycles
  // abort_iter: iteration index (0-based) whose WAIT gets an abort, -1 for none
  task automatic do_run(input logic [15:0] it_cfg, input logic [31:0] amax,
                        input logic [31:0] seed, input logic [31:0] mmask,
                        input int abort_iter, input bit no_status, input int stall);
    int          eff, exp_iter, exp_fail, n_seed, wait_cnt, delay;
    int          since_seed, since_stat, hold;
    bit          exp_to, exp_ab, lat_armed, am_pend, sd_pend, rdy;
    logic [31:0] exp_result, r;

    eff      = (it_cfg == 16'd0) ? 1 : int'(it_cfg);
    exp_to   = no_status;
    exp_ab   = (abort_iter >= 0) && !no_status;
    exp_iter = no_status ? 0 : (exp_ab ? abort_iter : eff);
    exp_fail = 0;
    for (int i = 0; i < exp_iter; i++) if (mmask[i % 32]) exp_fail++;
    if (exp_fail > 255) exp_fail = 255;
    exp_result = {exp_to, exp_ab, 6'b0, 8'(exp_fail), 16'(exp_iter)};

    start          = 1'b1;
    cfg_iterations = it_cfg;
    cfg_addr_max   = amax;
    cfg_seed       = seed;
    tick();
    start          = 1'b0;
    cfg_iterations = 16'($urandom());
    cfg_addr_max   = $urandom();
    cfg_seed       = $urandom();
    chk("start_latency", addr_max_tvalid, 1'b1);
    chk("busy_on_start", busy, 1'b1);

    n_seed = 0; wait_cnt = 0; delay = $urandom_range(0, 3);
    since_seed = 0; since_stat = 0; hold = 0;
    lat_armed = 0; am_pend = 0; sd_pend = 0;
    for (int cyc = 0; cyc < 5000 && !result_tvalid; cyc++) begin
      addr_max_tready = 1'b0;
      seed_tready     = 1'b0;
      status_tvalid   = 1'b0;
      abort           = 1'b0;
      if (am_pend) chk("addr_max_valid_held", addr_max_tvalid, 1'b1);
      if (sd_pend) chk("seed_valid_held", seed_tvalid, 1'b1);
      am_pend = 0;
      sd_pend = 0;
      chk("busy_in_run", busy, 1'b1);
      if (addr_max_tvalid) begin
        chk("addr_max_data", addr_max_tdata, amax);
        rdy = (stall == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        addr_max_tready = rdy;
        am_pend = !rdy;
      end
      if (seed_tvalid) begin
        if (lat_armed) begin
          chk("status_to_seed_latency", since_stat, 2);
          lat_armed = 0;
        end
        chk("seed_data", seed_tdata, seed + 32'(n_seed) * SEED_STEP);
        case (stall)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (hold >= 10);
        endcase
        hold++;
        seed_tready = rdy;
        sd_pend = !rdy;
        if (rdy) begin
          n_seed++;
          since_seed = -1;
          hold = 0;
        end
      end
      if (status_tready) begin
        wait_cnt++;
        if (abort_iter == n_seed - 1) begin
          if (wait_cnt == 2) abort = 1'b1;
        end else if (!no_status && wait_cnt > delay) begin
          r = $urandom();
          status_tdata  = {r[31:1], mmask[(n_seed - 1) % 32]};
          status_tvalid = 1'b1;
          wait_cnt  = 0;
          delay     = $urandom_range(0, 3);
          since_stat = 0;
          lat_armed = 1;
        end
      end else begin
        wait_cnt = 0;
      end
      tick();
      since_seed++;
      since_stat++;
    end
    addr_max_tready = 1'b0;
    seed_tready     = 1'b0;
    status_tvalid   = 1'b0;
    abort           = 1'b0;

    chk("result_arrived", result_tvalid, 1'b1);
    if (no_status) chk("timeout_latency", since_seed, TIMEOUT);
    chk("result_data", result_tdata, exp_result);
    chk("busy_at_report", busy, 1'b0);
    chk("status_tready_at_report", status_tready, 1'b0);
    chk("seed_tvalid_at_report", seed_tvalid, 1'b0);
    last_result = result_tdata;

    // start while the summary is pending must not begin a run
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pending_valid_held", result_tvalid, 1'b1);
      chk("pending_data_held", result_tdata, exp_result);
      chk("start_ignored_busy", busy, 1'b0);
      chk("start_ignored_addr_max", addr_max_tvalid, 1'b0);
    end
    result_tready = 1'b1;
    tick();
    result_tready = 1'b0;
    chk("result_consumed", result_tvalid, 1'b0);
    chk("result_data_cleared", result_tdata, 32'h0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", {busy, result_tvalid}, 2'b00);
  endtask

  initial begin
    int          eff, ab;
    logic [15:0] it;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_iterations = '0; cfg_addr_max = '0; cfg_seed = '0;
    addr_max_tready = 1'b0; seed_tready = 1'b0;
    status_tdata = '0; status_tvalid = 1'b0; result_tready = 1'b0;
    last_result = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // T1: plain three-iteration run
    do_run(16'd3, 32'hFF, 32'h1, 32'h0, -1, 1'b0, 0);
    chk("t1_result", last_result, 32'h0000_0003);

    // T2: second and fourth statuses report a mismatch
    do_run(16'd4, $urandom(), $urandom(), 32'b1010, -1, 1'b0, 0);
    chk("t2_result", last_result, 32'h0002_0004);

    // T3: seed_tready held low for 10 cycles per seed
    do_run(16'd3, $urandom(), $urandom(), $urandom(), -1, 1'b0, 2);

    // T4: status never arrives
    do_run(16'd2, $urandom(), $urandom(), 32'h0, -1, 1'b1, 0);
    chk("t4_result", last_result, 32'h8000_0000);

    // T5: abort during WAIT of the second iteration
    do_run(16'd5, $urandom(), $urandom(), 32'h0, 1, 1'b0, 0);
    chk("t5_result", last_result, 32'h4000_0001);

    // T6: reset while the seed is offered, then a clean run
    start = 1'b1; cfg_iterations = 16'd3; cfg_addr_max = 32'h55; cfg_seed = 32'h7;
    tick();
    start = 1'b0;
    addr_max_tready = 1'b1;
    for (int c = 0; c < 20 && !seed_tvalid; c++) tick();
    addr_max_tready = 1'b0;
    chk("t6_reached_set_seed", seed_tvalid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("t6_reset");
    repeat (3) tick();
    check_idle_outputs("t6_no_partial_summary");
    do_run(16'd3, 32'hFF, 32'h1, 32'h0, -1, 1'b0, 0);
    chk("t6_rerun_result", last_result, 32'h0000_0003);

    // iterations of zero behave as one
    do_run(16'd0, $urandom(), $urandom(), 32'h1, -1, 1'b0, 1);
    chk("zero_iter_result", last_result, 32'h0001_0001);

    // fail count saturates at 255
    do_run(16'd300, $urandom(), $urandom(), 32'hFFFF_FFFF, -1, 1'b0, 0);
    chk("saturate_result", last_result, 32'h00FF_012C);

    // seed wrap across 2^32
    do_run(16'd3, $urandom(), 32'hFFFF_FFF0, $urandom(), -1, 1'b0, 1);

    for (int k = 0; k < 8; k++) begin
      it  = 16'($urandom_range(0, 6));
      eff = (it == 16'd0) ? 1 : int'(it);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, eff - 1)) : -1;
      do_run(it, $urandom(), $urandom(), $urandom(), ab, 1'b0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
